// File: rtl/pe_col_driver_if.sv
// Source-side handshake bundle for the PE column driver: weight buffer and
// ifmap buffer valid/ready channels.
interface pe_col_driver_if #(
  parameter int DATA_W = 8
);
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_data;
  logic              if_ready;

  // Buffers act as master, the driver as slave.
  modport master (
    output w_valid, w_data, if_valid, if_data,
    input  w_ready, if_ready
  );

  modport slave (
    input  w_valid, w_data, if_valid, if_data,
    output w_ready, if_ready
  );
endinterface

// File: rtl/pe_col_driver.sv
// Drives one column of NUM_PE weight-stationary PEs: loads one weight per PE,
// streams ifmap samples into PE 0, then drains the chain before signalling done.
module pe_col_driver #(
  parameter int NUM_PE = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_ifmap,
  pe_col_driver_if.slave    src,
  output logic [DATA_W-1:0] w_in,
  output logic [NUM_PE-1:0] w_load_en,
  output logic              PE_en,
  output logic [DATA_W-1:0] ifmap,
  output logic              ifmap_vld,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_PE - 1);
  localparam logic [IDX_W-1:0]  DRAIN_LAST = IDX_W'(NUM_PE - 2);
  localparam logic [NUM_PE-1:0] ONE_HOT0   = NUM_PE'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] drain_q;
  logic             w_hs;
  logic             if_hs;

  assign src.w_ready  = (state_q == LOAD_W);
  assign src.if_ready = (state_q == STREAM);
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    w_hs    = (state_q == LOAD_W) && src.w_valid;
    if_hs   = (state_q == STREAM) && src.if_valid;
    case (state_q)
      IDLE:   if (start) state_d = LOAD_W;
      // A zero-length pass skips streaming but still drains the chain.
      LOAD_W: if (w_hs && (idx_q == IDX_LAST))
                state_d = (num_q == '0) ? DRAIN : STREAM;
      STREAM: if (if_hs && (cnt_q == num_q - CNT_W'(1))) state_d = DRAIN;
      DRAIN:  if (drain_q == DRAIN_LAST) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // PE_en and done lag the state by one cycle, so PE_en covers STREAM..DRAIN
  // shifted by one and done lands while the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      w_in      <= '0;
      w_load_en <= '0;
      PE_en     <= 1'b0;
      ifmap     <= '0;
      ifmap_vld <= 1'b0;
      done      <= 1'b0;
    end else begin
      w_load_en <= '0;
      ifmap     <= '0;
      ifmap_vld <= 1'b0;
      PE_en     <= (state_q == STREAM) || (state_q == DRAIN);
      done      <= (state_q == DONE);
      drain_q   <= (state_q == DRAIN) ? drain_q + IDX_W'(1) : '0;
      if ((state_q == IDLE) && start) begin
        num_q <= num_ifmap;
        cnt_q <= '0;
        idx_q <= '0;
      end
      if (w_hs) begin
        w_in      <= src.w_data;
        w_load_en <= ONE_HOT0 << idx_q;
        idx_q     <= idx_q + IDX_W'(1);
      end
      if (if_hs) begin
        ifmap     <= src.if_data;
        ifmap_vld <= 1'b1;
        cnt_q     <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_col_driver.sv
// Directed self-checking bench for pe_col_driver (NUM_PE=8, DATA_W=8, CNT_W=16).
module tb_pe_col_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_ifmap;
  logic [7:0]  w_in;
  logic [7:0]  w_load_en;
  logic        PE_en;
  logic [7:0]  ifmap;
  logic        ifmap_vld;
  logic        busy;
  logic        done;

  int pass_count  = 0;
  int check_count = 0;

  pe_col_driver_if #(.DATA_W(8)) src_if ();

  pe_col_driver #(.NUM_PE(8), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ifmap(num_ifmap),
    .src(src_if), .w_in(w_in), .w_load_en(w_load_en), .PE_en(PE_en),
    .ifmap(ifmap), .ifmap_vld(ifmap_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    else pass_count++;
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic st, input logic [15:0] n,
                               input logic wv, input logic [7:0] wd,
                               input logic iv, input logic [7:0] id);
    start           = st;
    num_ifmap       = n;
    src_if.w_valid  = wv;
    src_if.w_data   = wd;
    src_if.if_valid = iv;
    src_if.if_data  = id;
    @(posedge clk);
    #1;
  endtask

  task automatic loadWeights(input logic [7:0] base);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 16'd0, 1'b1, base + 8'(k), 1'b0, 8'd0);
      checkOutput($sformatf("w_load_en[%0d]", k), 32'(w_load_en), 32'(8'd1 << k));
      checkOutput($sformatf("w_in[%0d]", k), 32'(w_in), 32'(base + 8'(k)));
    end
  endtask

  task automatic drainAndDone(input logic start_mid);
    for (int d = 0; d < 7; d++) begin
      applyStimulus(start_mid && (d == 2), 16'd9, 1'b0, 8'd0, 1'b1, 8'hEE);
      checkOutput($sformatf("drain_PE_en[%0d]", d), 32'(PE_en), 32'd1);
      checkOutput($sformatf("drain_ifmap[%0d]", d), 32'({ifmap_vld, ifmap}), 32'd0);
      checkOutput($sformatf("drain_done[%0d]", d), 32'(done), 32'd0);
      checkOutput($sformatf("drain_if_ready[%0d]", d), 32'(src_if.if_ready), 32'd0);
    end
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_PE_en", 32'(PE_en), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    checkOutput("done_clear", 32'(done), 32'd0);
  endtask

  logic       w_pat  [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 1};
  logic       if_pat [4]  = '{1, 0, 1, 1};
  logic [7:0] if_dat [4]  = '{8'd21, 8'd99, 8'd22, 8'd23};
  logic [7:0] exp_if [4]  = '{8'd21, 8'd0, 8'd22, 8'd23};

  initial begin
    int k;
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_outs", 32'({PE_en, ifmap_vld, done, w_load_en, ifmap, w_in}), 32'd0);
    rst_n = 1'b1;

    // Pass 1: contiguous weights 1..8, samples 5..8 back to back.
    applyStimulus(1'b1, 16'd4, 1'b0, 8'd0, 1'b0, 8'd0);
    checkOutput("p1_busy", 32'(busy), 32'd1);
    checkOutput("p1_w_ready", 32'(src_if.w_ready), 32'd1);
    checkOutput("p1_if_ready_load", 32'(src_if.if_ready), 32'd0);
    loadWeights(8'd1);
    checkOutput("p1_if_ready", 32'(src_if.if_ready), 32'd1);
    checkOutput("p1_PE_en_entry", 32'(PE_en), 32'd0);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b1, 8'(5 + j));
      checkOutput($sformatf("p1_ifmap[%0d]", j), 32'(ifmap), 32'(5 + j));
      checkOutput($sformatf("p1_vld[%0d]", j), 32'(ifmap_vld), 32'd1);
      checkOutput($sformatf("p1_PE_en[%0d]", j), 32'(PE_en), 32'd1);
    end
    drainAndDone(1'b0);

    // Pass 2: weight backpressure gaps and an ifmap bubble.
    applyStimulus(1'b1, 16'd3, 1'b0, 8'd0, 1'b0, 8'd0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 16'd0, w_pat[c], 8'(11 + k), 1'b0, 8'd0);
      if (w_pat[c]) begin
        checkOutput($sformatf("p2_w_load_en[%0d]", c), 32'(w_load_en), 32'(8'd1 << k));
        checkOutput($sformatf("p2_w_in[%0d]", c), 32'(w_in), 32'(11 + k));
        k++;
      end else begin
        checkOutput($sformatf("p2_gap_en[%0d]", c), 32'(w_load_en), 32'd0);
        checkOutput($sformatf("p2_gap_w_in[%0d]", c), 32'(w_in), 32'(10 + k));
      end
    end
    checkOutput("p2_if_ready", 32'(src_if.if_ready), 32'd1);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, if_pat[j], if_dat[j]);
      checkOutput($sformatf("p2_ifmap[%0d]", j), 32'(ifmap), 32'(exp_if[j]));
      checkOutput($sformatf("p2_vld[%0d]", j), 32'(ifmap_vld), 32'(if_pat[j]));
      checkOutput($sformatf("p2_PE_en[%0d]", j), 32'(PE_en), 32'd1);
    end
    drainAndDone(1'b0);

    // Pass 3: zero samples, plus a start pulse while busy.
    applyStimulus(1'b1, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    loadWeights(8'd31);
    checkOutput("p3_if_ready", 32'(src_if.if_ready), 32'd0);
    drainAndDone(1'b1);
    checkOutput("p3_w_in_hold", 32'(w_in), 32'd38);

    // Pass 4: reset mid-stream aborts without a done pulse.
    applyStimulus(1'b1, 16'd4, 1'b0, 8'd0, 1'b0, 8'd0);
    loadWeights(8'd41);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b1, 8'd61);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b1, 8'd62);
    checkOutput("p4_ifmap_pre", 32'(ifmap), 32'd62);
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b1, 8'd63);
    checkOutput("p4_rst_busy", 32'(busy), 32'd0);
    checkOutput("p4_rst_outs", 32'({PE_en, ifmap_vld, done, w_load_en, ifmap}), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 1'b1, 8'd64);
      checkOutput($sformatf("p4_no_done[%0d]", c), 32'({busy, done, PE_en}), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
